// File: rtl/seq_det_pkg.sv
// rtl/seq_det_pkg.sv - shared types and constants for the time-shared 1010 detector
package seq_det_pkg;

    typedef enum logic [1:0] {
        S0 = 2'b00,
        S1 = 2'b01,
        S2 = 2'b10,
        S3 = 2'b11
    } state_t;

    // Pattern is consumed MSB first: PATTERN[3] is the first bit expected.
    localparam logic [3:0] PATTERN = 4'b1010;

endpackage

// File: rtl/seq_det_core.sv
// rtl/seq_det_core.sv - combinational overlapping Mealy step for one context
module seq_det_core
    import seq_det_pkg::*;
(
    input  state_t cur,
    input  logic   din,
    output state_t nxt,
    output logic   match
);

    // One detector step; fallback states are the overlap-preserving ones for 1010.
    always_comb begin
        nxt   = S0;
        match = 1'b0;
        case (cur)
            S0: nxt = (din == PATTERN[3]) ? S1 : S0;
            S1: nxt = (din == PATTERN[2]) ? S2 : S1;
            S2: nxt = (din == PATTERN[1]) ? S3 : S0;
            S3: begin
                if (din == PATTERN[0]) begin
                    nxt   = S2;
                    match = 1'b1;
                end else begin
                    nxt   = S1;
                end
            end
            // An upset encoding behaves exactly like S0.
            default: nxt = (din == PATTERN[3]) ? S1 : S0;
        endcase
    end

endmodule

// File: rtl/seq_det_scheduler.sv
// rtl/seq_det_scheduler.sv - round-robin time-sharing of one 1010 detector across channels
module seq_det_scheduler
    import seq_det_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int CH_W   = $clog2(NUM_CH),
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [NUM_CH-1:0] ch_en,
    input  logic [NUM_CH-1:0] ch_valid,
    input  logic [NUM_CH-1:0] ch_din,
    output logic [NUM_CH-1:0] ch_ready,
    input  logic              ctx_clr,
    output logic              match_valid,
    output logic [CH_W-1:0]   match_ch,
    output logic [CNT_W-1:0]  match_cnt
);

    state_t            ctx [NUM_CH];
    logic [CH_W-1:0]   ptr;
    logic [NUM_CH-1:0] req;
    logic [NUM_CH-1:0] grant;
    logic              gnt_any;
    logic [CH_W-1:0]   gnt_idx;

    state_t            core_cur;
    state_t            core_nxt;
    logic              core_din;
    logic              core_match;
    logic              hit;

    // A context clear suppresses every request so nothing is granted that cycle.
    assign req = ctx_clr ? '0 : (ch_valid & ch_en);

    // Rotating priority search starting at ptr, first requester wins.
    always_comb begin : arb
        logic [CH_W-1:0] idx;
        idx     = '0;
        grant   = '0;
        gnt_any = 1'b0;
        gnt_idx = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            idx = CH_W'((int'(ptr) + k) % NUM_CH);
            if (!gnt_any && req[idx]) begin
                gnt_any    = 1'b1;
                gnt_idx    = idx;
                grant[idx] = 1'b1;
            end
        end
    end

    // Grant is masked by reset so no channel sees ready while reset is held.
    assign ch_ready = grant & {NUM_CH{reset_n}};

    assign core_cur = ctx[gnt_idx];
    assign core_din = ch_din[gnt_idx];

    seq_det_core u_core (
        .cur   (core_cur),
        .din   (core_din),
        .nxt   (core_nxt),
        .match (core_match)
    );

    assign hit = gnt_any & core_match;

    // Pointer moves just past the granted channel and holds when idle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ptr <= '0;
        end else if (gnt_any) begin
            ptr <= (gnt_idx == CH_W'(NUM_CH - 1)) ? '0 : gnt_idx + 1'b1;
        end
    end

    // Per-channel contexts: cleared when disabled or on ctx_clr, advanced only when granted.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_CH; i++) ctx[i] <= S0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (ctx_clr || !ch_en[i]) begin
                    ctx[i] <= S0;
                end else if (gnt_any && (gnt_idx == CH_W'(i))) begin
                    ctx[i] <= core_nxt;
                end
            end
        end
    end

    // Registered match event; match_ch keeps the last matching channel between events.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            match_valid <= 1'b0;
            match_ch    <= '0;
        end else begin
            match_valid <= hit;
            if (hit) match_ch <= gnt_idx;
        end
    end

    // Saturating count of all matches since reset or the last ctx_clr.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            match_cnt <= '0;
        end else if (ctx_clr) begin
            match_cnt <= '0;
        end else if (hit && (match_cnt != {CNT_W{1'b1}})) begin
            match_cnt <= match_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_seq_det_scheduler.sv
// tb/tb_seq_det_scheduler.sv - directed self-checking bench for seq_det_scheduler
module tb_seq_det_scheduler;

    localparam int NUM_CH = 4;
    localparam int CH_W   = 2;
    localparam int CNT_W  = 4;

    logic              clk = 1'b0;
    logic              reset_n = 1'b0;
    logic [NUM_CH-1:0] ch_en = '0;
    logic [NUM_CH-1:0] ch_valid = '0;
    logic [NUM_CH-1:0] ch_din = '0;
    logic [NUM_CH-1:0] ch_ready;
    logic              ctx_clr = 1'b0;
    logic              match_valid;
    logic [CH_W-1:0]   match_ch;
    logic [CNT_W-1:0]  match_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    seq_det_scheduler #(
        .NUM_CH (NUM_CH),
        .CH_W   (CH_W),
        .CNT_W  (CNT_W)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .ch_en       (ch_en),
        .ch_valid    (ch_valid),
        .ch_din      (ch_din),
        .ch_ready    (ch_ready),
        .ctx_clr     (ctx_clr),
        .match_valid (match_valid),
        .match_ch    (match_ch),
        .match_cnt   (match_cnt)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset_n  = 1'b0;
        ch_en    = '0;
        ch_valid = '0;
        ch_din   = '0;
        ctx_clr  = 1'b0;
        tick();
        tick();
        reset_n  = 1'b1;
    endtask

    // Single requesting channel: drive one bit, expect it granted, check the next-cycle match.
    task automatic send_bit(input string tag, input int ch, input logic b, input logic exp_mv);
        ch_din = NUM_CH'(b) << ch;
        #1;
        check_eq({tag, "_rdy"}, 32'(ch_ready), 32'(1) << ch);
        tick();
        check_eq({tag, "_mv"}, 32'(match_valid), 32'(exp_mv));
        if (exp_mv) check_eq({tag, "_ch"}, 32'(match_ch), 32'(ch));
    endtask

    // ch0 and ch1 interleaved; streams are consumed MSB first.
    task automatic run_two(input string tag, input logic [3:0] s0, input logic [3:0] s1,
                           input logic exp_ch1);
        int idx0;
        int idx1;
        int g;
        idx0 = 0;
        idx1 = 0;
        do_reset();
        ch_en    = 4'b0011;
        ch_valid = 4'b0011;
        for (int k = 0; k < 8; k++) begin
            g = k % 2;
            ch_din = {2'b00, s1[3 - (idx1 % 4)], s0[3 - (idx0 % 4)]};
            #1;
            check_eq({tag, "_rdy"}, 32'(ch_ready), 32'(1) << g);
            tick();
            if (g == 0) idx0++; else idx1++;
            if (k == 6) begin
                check_eq({tag, "_mv0"}, 32'(match_valid), 32'd1);
                check_eq({tag, "_ch0"}, 32'(match_ch), 32'd0);
            end else if (k == 7) begin
                check_eq({tag, "_mv1"}, 32'(match_valid), 32'(exp_ch1));
                if (exp_ch1) check_eq({tag, "_ch1"}, 32'(match_ch), 32'd1);
            end else begin
                check_eq({tag, "_mvq"}, 32'(match_valid), 32'd0);
            end
        end
        ch_valid = '0;
    endtask

    initial begin
        // Reset state, with requests pending while reset is held
        reset_n  = 1'b0;
        ch_en    = 4'b1111;
        ch_valid = 4'b1111;
        tick();
        check_eq("rst_rdy", 32'(ch_ready), 32'd0);
        check_eq("rst_mv", 32'(match_valid), 32'd0);
        check_eq("rst_ch", 32'(match_ch), 32'd0);
        check_eq("rst_cnt", 32'(match_cnt), 32'd0);

        // ch0 alone: 101010 gives overlapping matches on bits 4 and 6
        do_reset();
        ch_en    = 4'b0001;
        ch_valid = 4'b0001;
        send_bit("t1b0", 0, 1'b1, 1'b0);
        send_bit("t1b1", 0, 1'b0, 1'b0);
        send_bit("t1b2", 0, 1'b1, 1'b0);
        send_bit("t1b3", 0, 1'b0, 1'b1);
        send_bit("t1b4", 0, 1'b1, 1'b0);
        send_bit("t1b5", 0, 1'b0, 1'b1);
        ch_valid = '0;
        check_eq("t1_cnt", 32'(match_cnt), 32'd2);

        // Two interleaved channels, then a non-matching ch1 stream
        run_two("t2a", 4'b1010, 4'b1010, 1'b1);
        check_eq("t2a_cnt", 32'(match_cnt), 32'd2);
        run_two("t2b", 4'b1010, 4'b1100, 1'b0);
        check_eq("t2b_cnt", 32'(match_cnt), 32'd1);

        // All channels requesting: strict rotation from ptr=0
        do_reset();
        ch_en    = 4'b1111;
        ch_valid = 4'b1111;
        ch_din   = '0;
        for (int k = 0; k < 5; k++) begin
            #1;
            check_eq("t3_rdy", 32'(ch_ready), 32'(1) << (k % 4));
            tick();
        end
        ch_valid = '0;

        // ch2: disable mid-pattern discards the partial 101
        do_reset();
        ch_en    = 4'b0100;
        ch_valid = 4'b0100;
        send_bit("t4b0", 2, 1'b1, 1'b0);
        send_bit("t4b1", 2, 1'b0, 1'b0);
        send_bit("t4b2", 2, 1'b1, 1'b0);
        ch_en = 4'b0000;
        #1;
        check_eq("t4_dis_rdy", 32'(ch_ready), 32'd0);
        tick();
        check_eq("t4_dis_mv", 32'(match_valid), 32'd0);
        ch_en = 4'b0100;
        send_bit("t4b3", 2, 1'b0, 1'b0);
        send_bit("t4b4", 2, 1'b1, 1'b0);
        send_bit("t4b5", 2, 1'b0, 1'b0);
        send_bit("t4b6", 2, 1'b1, 1'b0);
        send_bit("t4b7", 2, 1'b0, 1'b1);
        check_eq("t4_cnt", 32'(match_cnt), 32'd1);

        // ch0 101 then asynchronous reset mid-cycle; trailing 0 must not match
        ch_en    = 4'b0001;
        ch_valid = 4'b0001;
        send_bit("t5b0", 0, 1'b1, 1'b0);
        send_bit("t5b1", 0, 1'b0, 1'b0);
        send_bit("t5b2", 0, 1'b1, 1'b0);
        ch_din = 4'b0000;
        #3;
        reset_n = 1'b0;
        #1;
        check_eq("t5_async_rdy", 32'(ch_ready), 32'd0);
        check_eq("t5_async_cnt", 32'(match_cnt), 32'd0);
        check_eq("t5_async_mv", 32'(match_valid), 32'd0);
        tick();
        check_eq("t5_hold_rdy", 32'(ch_ready), 32'd0);
        reset_n = 1'b1;
        send_bit("t5b3", 0, 1'b0, 1'b0);
        check_eq("t5_cnt", 32'(match_cnt), 32'd0);

        // Counter saturation at 15 after 19 matches, then ctx_clr
        do_reset();
        ch_en    = 4'b0001;
        ch_valid = 4'b0001;
        send_bit("t6p0", 0, 1'b1, 1'b0);
        send_bit("t6p1", 0, 1'b0, 1'b0);
        for (int m = 1; m <= 19; m++) begin
            send_bit("t6h", 0, 1'b1, 1'b0);
            send_bit("t6l", 0, 1'b0, 1'b1);
            if (m == 14) check_eq("t6_cnt14", 32'(match_cnt), 32'd14);
            if (m == 16) check_eq("t6_cnt16", 32'(match_cnt), 32'd15);
        end
        check_eq("t6_sat", 32'(match_cnt), 32'd15);
        ctx_clr = 1'b1;
        #1;
        check_eq("t6_clr_rdy", 32'(ch_ready), 32'd0);
        tick();
        ctx_clr = 1'b0;
        check_eq("t6_clr_cnt", 32'(match_cnt), 32'd0);
        check_eq("t6_clr_mv", 32'(match_valid), 32'd0);
        send_bit("t6c0", 0, 1'b1, 1'b0);
        send_bit("t6c1", 0, 1'b0, 1'b0);
        send_bit("t6c2", 0, 1'b1, 1'b0);
        send_bit("t6c3", 0, 1'b0, 1'b1);
        check_eq("t6_post_cnt", 32'(match_cnt), 32'd1);
        ch_valid = '0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/seq_det_scheduler.md
Name: seq_det_scheduler

Overview:
- Time-shares one "1010" overlapping Mealy detection engine across NUM_CH independent serial bit streams.
- Each channel offers one bit per transfer through a valid/ready handshake.
- A round-robin arbiter grants one channel per cycle. The engine advances that channel's saved 2-bit context and flags a match.
- Sits between the serial front-end lanes and the match-event logger.

Parameters:
NUM_CH, 4, number of serial input channels (2..16)
CH_W, $clog2(NUM_CH), channel-index width
CNT_W, 16, width of the saturating global match counter

Ports:
clk  input  1  rising-edge clock
reset_n  input  1  asynchronous active-low reset
ch_en  input  NUM_CH  per-channel enable mask
ch_valid  input  NUM_CH  per-channel bit-valid
ch_din  input  NUM_CH  per-channel serial bit
ch_ready  output  NUM_CH  one-hot grant; transfer when ch_valid[i] & ch_ready[i]
ctx_clr  input  1  synchronous pulse: return all contexts to S0
match_valid  output  1  registered pulse: granted bit completed "1010"
match_ch  output  CH_W  channel index of the match; valid with match_valid
match_cnt  output  CNT_W  total matches since reset/ctx_clr, saturating

Behaviour:
- Clock and reset: one clock. reset_n is asynchronous, active-low.
- Reset values: all contexts = S0, RR pointer = 0, match_valid = 0, match_ch = 0, match_cnt = 0.
- ch_ready is combinational and depends only on registered state and current inputs. It is 0 throughout reset.
- Request vector: req = ch_valid & ch_en. ctx_clr forces req to 0, so there is no grant that cycle.
- Arbitration:
  - Search req starting at index ptr and wrapping modulo NUM_CH. The first set bit wins, and ch_ready is one-hot on it.
  - On a grant to channel g, ptr <= (g+1) mod NUM_CH.
  - With no request, ptr holds and ch_ready = 0.
- Engine transitions, per context (state, din -> next, match):
  - S0: 0->S0, 1->S1
  - S1: 0->S2, 1->S1
  - S2: 0->S0, 1->S3
  - S3: 0->S2 with match=1, 1->S1
  - Overlap: after a match the context is S2, so "101010" yields two matches.
- Context update: only ctx[g] is written on a transfer. Other channels' contexts are untouched.
- Latency: a bit transferred in cycle t gives match_valid=1 and match_ch=g in cycle t+1. match_valid is 0 in every cycle with no match.
- Throughput: 1 bit per cycle aggregate. A channel waits at most NUM_CH-1 cycles when all channels request.
- ch_en[i] deasserted: ctx[i] <= S0 in that cycle, and channel i is never granted while disabled. Re-enabling restarts detection from S0.
- ctx_clr (one cycle):
  - All contexts <= S0 and match_cnt <= 0.
  - match_valid of the following cycle is 0.
  - ptr is unchanged.
- match_cnt increments on each match and holds at 2^CNT_W-1.
- Illegal context encodings (SEU): treated as S0.
- reset_n asserted mid-stream: immediate return to reset values. Partial patterns are lost, and no match is emitted for the interrupted bit.

Decomposition:
- Package seq_det_pkg holds:
  - state_t: 2-bit enum S0=00, S1=01, S2=10, S3=11.
  - PATTERN constant 4'b1010.
- One sub-module, seq_det_core: purely combinational.
  - Inputs: state_t cur, din.
  - Outputs: state_t nxt, match.
  - Instanced once and shared by all channels.
- Arbiter, context array, pointer and counter stay in the top.

Test Plan:
- NUM_CH=4, only ch0 enabled and valid, bits 1,0,1,0,1,0 on consecutive cycles -> match_valid 1 cycle after the 4th and 6th bits, match_ch=0, match_cnt=2.
- ch0 and ch1 both streaming 1,0,1,0, interleaved by the arbiter -> grants alternate 0,1,0,1…. Two matches: match_ch=0, then match_ch=1 one cycle later. No cross-channel contamination; ch1 stream 1,1,0,0 alongside gives no ch1 match.
- All 4 channels valid continuously from ptr=0 -> ch_ready sequence 0001, 0010, 0100, 1000, 0001; each channel gets exactly 1 grant per 4 cycles.
- ch2 sends 1,0,1, then ch_en[2]=0 for one cycle, re-enabled, then sends 0 -> no match. A following 1,0 after a fresh 1,0 pair (1,0,1,0) -> match_ch=2.
- ch0 sends 1,0,1, then reset_n=0 asynchronously mid-cycle -> ch_ready=0, match_cnt=0 immediately. After release, 0 on ch0 -> no match.
- Drive 2^CNT_W+3 matches (CNT_W overridden to 4) -> match_cnt stops at 15. ctx_clr pulse -> match_cnt=0, ch_ready=0 that cycle, next match counts to 1.
